// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// master = stream source / memory side, slave = loader.
interface imem_loader_if;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data,
        input  busy, cpu_hold, done, err
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data,
        output busy, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK    = 3'd5;
    localparam logic [2:0] S_TAIL   = S_CHK;
`endif
    localparam logic [2:0] S_FIN    = 3'd6;
`ifndef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_TAIL   = S_FIN;
`endif

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [16:0] idx_q, idx_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wen_q, wen_d;
    logic        err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic        take;
    logic        in_range;
    logic [16:0] idx_inc;
    logic [15:0] len_nxt;
    logic [31:0] word_nxt;

    assign take     = bus.byte_valid & bus.byte_ready;
    assign idx_inc  = idx_q + 17'd1;
    assign len_nxt  = {len_q[15:8], bus.byte_data};
    assign word_nxt = {word_q[23:0], bus.byte_data};
    assign in_range = {15'd0, idx_q} < 32'(DEPTH);

    assign bus.byte_ready = (state_q == S_LEN_HI) | (state_q == S_LEN_LO)
`ifdef IMEM_LOADER_CHECKSUM_EN
                          | (state_q == S_CHK)
`endif
                          | (state_q == S_DATA);
    assign bus.busy     = (state_q != S_IDLE) & (state_q != S_FIN);
    assign bus.cpu_hold = bus.busy;
    assign bus.done     = (state_q == S_FIN);
    assign bus.wr_en    = wen_q;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = data_q;
    assign bus.err      = err_q;

    // Session FSM: length, word assembly, write strobe and error tracking
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wen_d   = 1'b0;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = take ? (sum_q ^ bus.byte_data) : sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LEN_HI;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (take) begin
                    len_d   = {bus.byte_data, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (take) begin
                    len_d   = len_nxt;
                    state_d = (len_nxt == 16'd0) ? S_TAIL : S_DATA;
                end
            end
            S_DATA: begin
                if (take) begin
                    cnt_d  = cnt_q + 2'd1;
                    word_d = word_nxt;
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        data_d  = word_nxt;
                        addr_d  = BASE_ADDR + {13'd0, idx_q, 2'b00};
                        wen_d   = in_range;
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_inc;
                if (!in_range) err_d = 1'b1;
                state_d = (idx_inc < {1'b0, len_q}) ? S_DATA : S_TAIL;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (take) begin
                    if (bus.byte_data != sum_q) err_d = 1'b1;
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous abort to an idle, quiet loader
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: DEPTH=256 and DEPTH=2 instances
// driven by the same stream, outputs checked against hand-computed values.
module tb_imem_loader;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       bv;
    logic [7:0] bd;

    int total = 0;
    int fails = 0;
    int cyc = 0;

    imem_loader_if a ();
    imem_loader_if b ();

    assign a.start      = start;
    assign a.byte_valid = bv;
    assign a.byte_data  = bd;
    assign b.start      = start;
    assign b.byte_valid = bv;
    assign b.byte_data  = bd;

    imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .bus(a)
    );
    imem_loader #(.DEPTH(2), .BASE_ADDR(32'h0)) dut2 (
        .clk(clk), .reset(reset), .bus(b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    logic [31:0] wa1[$], wd1[$], wa2[$], wd2[$];
    int          wc1[$];
    int          acc_cyc[$];
    int          done1 = 0, done2 = 0, dbl = 0;
    logic        pw1 = 1'b0, pw2 = 1'b0;
    logic [7:0]  stream[$];

    always @(negedge clk) begin
        if (a.wr_en) begin
            wa1.push_back(a.wr_addr);
            wd1.push_back(a.wr_data);
            wc1.push_back(cyc);
        end
        if (b.wr_en) begin
            wa2.push_back(b.wr_addr);
            wd2.push_back(b.wr_data);
        end
        if (a.wr_en && pw1) dbl++;
        if (b.wr_en && pw2) dbl++;
        pw1 = a.wr_en;
        pw2 = b.wr_en;
        if (a.done) done1++;
        if (b.done) done2++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wa1.delete(); wd1.delete(); wc1.delete();
        wa2.delete(); wd2.delete(); acc_cyc.delete();
        dbl = 0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        logic acc = 1'b0;
        int   t = 0;
        bv = 1'b1;
        bd = v;
        while (!acc && t < 50) begin
            acc = a.byte_ready;
            @(negedge clk);
            t++;
        end
        bv = 1'b0;
        if (acc) acc_cyc.push_back(cyc);
        chk("byte_accept", {31'd0, acc}, 32'd1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic session(input int gap, input bit bad_ck);
        logic [7:0] x = 8'h00;
        clr();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on", {31'd0, a.busy}, 32'd1);
        chk("hold_on", {31'd0, a.cpu_hold}, 32'd1);
        chk("err_cleared", {31'd0, b.err}, 32'd0);
        foreach (stream[i]) begin
            x = x ^ stream[i];
            send_byte(stream[i], gap);
        end
        if (CK_EN) send_byte(bad_ck ? 8'hFF : x, gap);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2;
        reset = 1'b1;
        start = 1'b0;
        bv    = 1'b0;
        bd    = 8'h00;
        #2;
        chk("rst_ready", {31'd0, a.byte_ready}, 32'd0);
        chk("rst_busy", {31'd0, a.busy}, 32'd0);
        chk("rst_done", {31'd0, a.done}, 32'd0);
        chk("rst_err", {31'd0, a.err}, 32'd0);
        chk("rst_wr_en", {31'd0, a.wr_en}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single word
        stream = '{8'h00, 8'h01, 8'h20, 8'h04, 8'h00, 8'h0A};
        d1 = done1;
        session(0, 1'b0);
        chk("s1_nwr", wa1.size(), 1);
        if (wa1.size() == 1) begin
            chk("s1_addr", wa1[0], 32'h0);
            chk("s1_data", wd1[0], 32'h2004000A);
            chk("s1_latency", wc1[0], acc_cyc[5]);
        end
        chk("s1_done", done1 - d1, 1);
        chk("s1_err", {31'd0, a.err}, 32'd0);
        chk("s1_busy_off", {31'd0, a.busy}, 32'd0);
        chk("s1_hold_off", {31'd0, a.cpu_hold}, 32'd0);

        // Three words, valid held high; DEPTH=2 instance overflows
        stream = '{8'h00, 8'h03,
                   8'h00, 8'h22, 8'h18, 8'h20,
                   8'h20, 8'h24, 8'h00, 8'h0A,
                   8'h00, 8'h82, 8'h28, 8'h24};
        for (int g = 0; g < 2; g++) begin
            d1 = done1;
            d2 = done2;
            session(g, 1'b0);
            chk("s2_nwr", wa1.size(), 3);
            if (wa1.size() == 3) begin
                chk("s2_a0", wa1[0], 32'h0);
                chk("s2_a1", wa1[1], 32'h4);
                chk("s2_a2", wa1[2], 32'h8);
                chk("s2_d0", wd1[0], 32'h00221820);
                chk("s2_d1", wd1[1], 32'h2024000A);
                chk("s2_d2", wd1[2], 32'h00822824);
            end
            chk("s2_pulse1", dbl, 0);
            chk("s2_done", done1 - d1, 1);
            chk("s2_err", {31'd0, a.err}, 32'd0);
            chk("ovf_nwr", wa2.size(), 2);
            if (wa2.size() == 2) begin
                chk("ovf_a1", wa2[1], 32'h4);
                chk("ovf_d1", wd2[1], 32'h2024000A);
            end
            chk("ovf_err", {31'd0, b.err}, 32'd1);
            chk("ovf_done", done2 - d2, 1);
            chk("ovf_idle", {31'd0, b.busy}, 32'd0);
        end

        // Zero-length session, bad checksum when enabled
        stream = '{8'h00, 8'h00};
        d1 = done1;
        session(0, 1'b1);
        chk("n0_nwr", wa1.size(), 0);
        chk("n0_done", done1 - d1, 1);
        chk("n0_err", {31'd0, a.err}, {31'd0, CK_EN});

        // Abort mid-word, then a clean session
        clr();
        d1 = done1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        send_byte(8'h04, 0);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, a.busy}, 32'd0);
        chk("abort_hold", {31'd0, a.cpu_hold}, 32'd0);
        chk("abort_ready", {31'd0, a.byte_ready}, 32'd0);
        chk("abort_addr", a.wr_addr, 32'h0);
        chk("abort_data", a.wr_data, 32'h0);
        chk("abort_err2", {31'd0, b.err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_nwr", wa1.size(), 0);
        chk("abort_nodone", done1 - d1, 0);
        stream = '{8'h00, 8'h01, 8'h20, 8'h04, 8'h00, 8'h0A};
        d1 = done1;
        session(0, 1'b0);
        chk("re_nwr", wa1.size(), 1);
        if (wa1.size() == 1) begin
            chk("re_addr", wa1[0], 32'h0);
            chk("re_data", wd1[0], 32'h2004000A);
        end
        chk("re_done", done1 - d1, 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, instruction memory size in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first loaded word.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a load session.
REQ-006 SHALL have port byte_valid, input, 1, a byte is offered on byte_data.
REQ-007 SHALL have port byte_data, input, 8, the incoming stream byte.
REQ-008 SHALL have port byte_ready, output, 1, the loader accepts byte_data this cycle.
REQ-009 SHALL have port wr_en, output, 1, instruction memory write strobe.
REQ-010 SHALL have port wr_addr, output, 32, word-aligned byte address of the write (bits [1:0]=0).
REQ-011 SHALL have port wr_data, output, 32, instruction word to write.
REQ-012 SHALL have port busy, output, 1, a session is in progress.
REQ-013 SHALL have port cpu_hold, output, 1, holds the processor while busy.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse at session end.
REQ-015 SHALL have port err, output, 1, sticky error flag, cleared by the next start.

Function
REQ-016 A byte SHALL transfer only in a cycle where byte_valid=1 and byte_ready=1.
REQ-017 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, FIN.
REQ-018 IDLE: byte_ready=0; start=1 SHALL move to LEN_HI, clear err, zero the word index, and set busy and cpu_hold.
REQ-019 LEN_HI/LEN_LO: the two accepted bytes SHALL form the 16-bit word count N, big-endian.
REQ-020 After LEN_LO, N=0 SHALL go to CHK (or FIN if the CHK stage is compiled out); otherwise the FSM SHALL go to DATA.
REQ-021 DATA: four accepted bytes SHALL assemble one word big-endian (first byte = bits [31:24]); after the fourth byte the FSM SHALL enter WRITE.
REQ-022 WRITE: lasts exactly one cycle with byte_ready=0; wr_en=1, wr_data=the assembled word, wr_addr=BASE_ADDR+4*index; the index then increments.
REQ-023 After WRITE, the FSM SHALL return to DATA if index<N, else go to CHK (or FIN).
REQ-024 If index>=DEPTH in WRITE, wr_en SHALL stay 0, err SHALL be set, and the stream SHALL still be consumed to the end.
REQ-025 FIN: done=1 for one cycle, busy and cpu_hold deasserted in the same cycle, then IDLE.
REQ-026 start while busy SHALL be ignored.
REQ-027 byte_valid with byte_ready=0 SHALL NOT be consumed; the sender holds the byte.
REQ-028 wr_en SHALL be 0 in every state except WRITE.
REQ-029 Latency: wr_en SHALL assert in the cycle after the fourth byte handshake of a word.
REQ-030 byte_ready SHALL be 1 in LEN_HI, LEN_LO, DATA and CHK, and 0 in all other states.

Reset
REQ-031 On reset assertion, without waiting for clk: state=IDLE; byte_ready, wr_en, busy, cpu_hold, done and err all 0; wr_addr=0, wr_data=0; byte assembly and index cleared.
REQ-032 Reset mid-session SHALL abort it with no further write and no done pulse.

Configuration
REQ-033 Macro IMEM_LOADER_CHECKSUM_EN, when defined: the CHK state SHALL accept one byte after the data; if it differs from the XOR of all prior session bytes (length bytes included), err SHALL be set; FIN then follows.
REQ-034 Without IMEM_LOADER_CHECKSUM_EN: the CHK state SHALL not exist, no trailing byte is consumed, and the checksum SHALL never set err.

Verification
REQ-035 start, stream 00 01 20 04 00 0A (then checksum 2F if enabled), valid held high -> one write, addr 0x0, data 0x2004000A; done one cycle later; err=0.
REQ-036 N=3, words 0x00221820, 0x2024000A, 0x00822824 -> writes to 0x0, 0x4, 0x8 in order, each wr_en high exactly 1 cycle.
REQ-037 byte_valid toggled every other cycle -> same writes as REQ-036; no byte lost or duplicated.
REQ-038 DEPTH=2, N=3 -> writes to 0x0 and 0x4 only, err=1, done pulses, stream fully consumed.
REQ-039 Reset asserted after the second data byte -> all outputs 0 immediately; a following clean session writes correctly from BASE_ADDR.
REQ-040 With IMEM_LOADER_CHECKSUM_EN, N=0 and wrong checksum byte 0xFF -> no writes, err=1, done=1.
